// File: rtl/zx_pkg.sv
// zx_pkg: constants shared by the ZX Spectrum memory mapper.
//   - I/O port addresses for the 128K paging port (7FFD) and the +3 port (1FFD)
//   - fixed bank numbers mapped at 4000 and 8000
//   - paging scheme encodings used by the MODE parameter
//   - the +3 all-RAM bank table, exposed as a lookup function
package zx_pkg;

  localparam logic [15:0] PORT_7FFD = 16'h7FFD;
  localparam logic [15:0] PORT_1FFD = 16'h1FFD;

  // Banks permanently mapped at 4000-7FFF and 8000-BFFF in the normal map.
  localparam logic [5:0] BANK_4000 = 6'd5;
  localparam logic [5:0] BANK_8000 = 6'd2;

  localparam int MODE_128K     = 0;
  localparam int MODE_PENTAGON = 1;
  localparam int MODE_PLUS3    = 2;

  // +3 all-RAM configurations: sel = 1FFD[2:1], slot = A[15:14].
  function automatic logic [2:0] plus3_bank(input logic [1:0] sel, input logic [1:0] slot);
    logic [2:0] bank;
    case ({sel, slot})
      4'b00_00: bank = 3'd0;
      4'b00_01: bank = 3'd1;
      4'b00_10: bank = 3'd2;
      4'b00_11: bank = 3'd3;
      4'b01_00: bank = 3'd4;
      4'b01_01: bank = 3'd5;
      4'b01_10: bank = 3'd6;
      4'b01_11: bank = 3'd7;
      4'b10_00: bank = 3'd4;
      4'b10_01: bank = 3'd5;
      4'b10_10: bank = 3'd6;
      4'b10_11: bank = 3'd3;
      4'b11_00: bank = 3'd4;
      4'b11_01: bank = 3'd7;
      4'b11_10: bank = 3'd6;
      default:  bank = 3'd3;
    endcase
    return bank;
  endfunction

endpackage

// File: rtl/zx_strobe_edge.sv
// zx_strobe_edge: registers a (decoded, active-high) Z80 strobe once and
// emits a one-clock pulse on its rising edge, so a bus cycle of any length
// produces a single action.
// Ports:
//   clock    block clock
//   reset_n  synchronous active-low reset
//   strobe   decoded strobe level (1 = bus cycle active)
//   pulse    high for the one clock after the first sampled assertion
module zx_strobe_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic strobe,
  output logic pulse
);

  logic level_q;
  logic prev_q;

  // History is reset to "asserted": a strobe still held across reset
  // release looks like a continuing cycle, not a new one.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      level_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      level_q <= strobe;
      prev_q  <= level_q;
    end
  end

  assign pulse = level_q & ~prev_q;

endmodule

// File: rtl/zx_memory_mapper.sv
// zx_memory_mapper: ZX Spectrum 128K / Pentagon / +3 memory paging.
// Decodes writes to ports 7FFD and 1FFD, holds the paging registers and
// translates the Z80 address into a physical RAM or ROM address.
// Ports:
//   clock, reset_n          block clock, synchronous active-low reset
//   A, D                    Z80 address bus and write data
//   nMREQ, nIORQ, nRD, nWR  Z80 strobes (active low)
//   mem_addr, rom_addr      physical RAM / ROM address (combinational from A)
//   rom_sel                 current address targets ROM (combinational)
//   mem_we                  one-clock RAM write pulse per Z80 memory write
//   screen_bank             0 = bank 5, 1 = bank 7
//   paging_locked           7FFD lock bit (always 0 with 64 banks)
//   port_7ffd, port_1ffd    paging register mirrors
module zx_memory_mapper
  import zx_pkg::*;
#(
  parameter int RAM_BANKS   = 8,
  parameter int ROM_PAGES   = 2,
  parameter int MODE        = 0,
  parameter int FULL_DECODE = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [15:0]                    A,
  input  logic [7:0]                     D,
  input  logic                           nMREQ,
  input  logic                           nIORQ,
  input  logic                           nRD,
  input  logic                           nWR,
  output logic [$clog2(RAM_BANKS)+13:0]  mem_addr,
  output logic [$clog2(ROM_PAGES)+13:0]  rom_addr,
  output logic                           rom_sel,
  output logic                           mem_we,
  output logic                           screen_bank,
  output logic                           paging_locked,
  output logic [7:0]                     port_7ffd,
  output logic [7:0]                     port_1ffd
);

  localparam int BANK_W = $clog2(RAM_BANKS);
  localparam int ROM_W  = $clog2(ROM_PAGES);

  logic        io_wr;
  logic        mem_wr;
  logic        io_pulse;
  logic        mem_pulse;
  logic [15:0] a_q;
  logic [7:0]  d_q;

  assign io_wr  = ~nIORQ & ~nWR & nRD;
  assign mem_wr = ~nMREQ & ~nWR;

  zx_strobe_edge u_io_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe  (io_wr),
    .pulse   (io_pulse)
  );

  zx_strobe_edge u_mem_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .strobe  (mem_wr),
    .pulse   (mem_pulse)
  );

  // Address and data are captured alongside the strobes, so the action
  // taken on the pulse uses the bus values from the sampling edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q <= 16'h0000;
      d_q <= 8'h00;
    end else begin
      a_q <= A;
      d_q <= D;
    end
  end

  logic all_ram;
  logic hit_7ffd;
  logic hit_1ffd;
  logic rom_sel_q;

  assign all_ram = (MODE == MODE_PLUS3) && port_1ffd[0];

  always_comb begin
    hit_7ffd = 1'b0;
    hit_1ffd = 1'b0;
    if (FULL_DECODE != 0) begin
      hit_7ffd = (a_q == PORT_7FFD);
      hit_1ffd = (MODE == MODE_PLUS3) && (a_q == PORT_1FFD);
    end else begin
      if (MODE == MODE_PLUS3) begin
        hit_7ffd = (a_q[15:14] == 2'b01) && !a_q[1];
        hit_1ffd = (a_q[15:12] == 4'b0001) && !a_q[1];
      end else begin
        hit_7ffd = !a_q[15] && !a_q[1];
      end
    end
  end

  // ROM/RAM decision for the address that the pending memory write used.
  assign rom_sel_q = (a_q[15:14] == 2'b00) && !all_ram;

  assign paging_locked = (RAM_BANKS != 64) ? port_7ffd[5] : 1'b0;
  assign screen_bank   = port_7ffd[3];

  // A port write and a memory write cannot coincide on a real Z80; if they
  // ever do, the port write is taken and the RAM write is dropped.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      port_7ffd <= 8'h00;
      port_1ffd <= 8'h00;
      mem_we    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (io_pulse) begin
        if (!paging_locked) begin
          if (hit_7ffd) port_7ffd <= d_q;
          if (hit_1ffd) port_1ffd <= d_q;
        end
      end else if (mem_pulse && !rom_sel_q) begin
        mem_we <= 1'b1;
      end
    end
  end

  logic [5:0] sel_bank;
  logic [5:0] slot_bank;
  logic [1:0] rom_page;

  always_comb begin
    sel_bank = {3'b000, port_7ffd[2:0]};
    if (MODE != MODE_128K && RAM_BANKS >= 32) sel_bank[4:3] = port_7ffd[7:6];
    if (RAM_BANKS == 64)                      sel_bank[5]   = port_7ffd[5];

    slot_bank = 6'd0;
    if (all_ram) begin
      slot_bank = {3'b000, plus3_bank(port_1ffd[2:1], A[15:14])};
    end else begin
      case (A[15:14])
        2'b01:   slot_bank = BANK_4000;
        2'b10:   slot_bank = BANK_8000;
        2'b11:   slot_bank = sel_bank;
        default: slot_bank = 6'd0;
      endcase
    end

    rom_page    = {1'b0, port_7ffd[4]};
    if (MODE == MODE_PLUS3 && ROM_PAGES == 4) rom_page[1] = port_1ffd[2];
  end

  assign rom_sel  = (A[15:14] == 2'b00) && !all_ram;
  assign mem_addr = {slot_bank[BANK_W-1:0], A[13:0]};
  assign rom_addr = {rom_page[ROM_W-1:0], A[13:0]};

endmodule

// File: tb/tb_zx_memory_mapper.sv
// Three mapper configurations share one Z80 bus:
//   0: 8 banks, 2 ROMs, 128K,     full decode
//   1: 64 banks, 2 ROMs, Pentagon, full decode
//   2: 8 banks, 4 ROMs, +3,        partial decode
module tb_zx_memory_mapper;

  logic        clock;
  logic        reset_n;
  logic [15:0] A;
  logic [7:0]  D;
  logic        nMREQ, nIORQ, nRD, nWR;

  logic [16:0] mem_addr0, mem_addr2;
  logic [19:0] mem_addr1;
  logic [14:0] rom_addr0, rom_addr1;
  logic [15:0] rom_addr2;
  logic        rom_sel0, rom_sel1, rom_sel2;
  logic        mem_we0, mem_we1, mem_we2;
  logic        screen0, screen1, screen2;
  logic        locked0, locked1, locked2;
  logic [7:0]  p7_0, p7_1, p7_2, p1_0, p1_1, p1_2;

  zx_memory_mapper #(.RAM_BANKS(8), .ROM_PAGES(2), .MODE(0), .FULL_DECODE(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .mem_addr(mem_addr0), .rom_addr(rom_addr0), .rom_sel(rom_sel0), .mem_we(mem_we0),
    .screen_bank(screen0), .paging_locked(locked0), .port_7ffd(p7_0), .port_1ffd(p1_0));

  zx_memory_mapper #(.RAM_BANKS(64), .ROM_PAGES(2), .MODE(1), .FULL_DECODE(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .mem_addr(mem_addr1), .rom_addr(rom_addr1), .rom_sel(rom_sel1), .mem_we(mem_we1),
    .screen_bank(screen1), .paging_locked(locked1), .port_7ffd(p7_1), .port_1ffd(p1_1));

  zx_memory_mapper #(.RAM_BANKS(8), .ROM_PAGES(4), .MODE(2), .FULL_DECODE(0)) dut2 (
    .clock(clock), .reset_n(reset_n), .A(A), .D(D),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .mem_addr(mem_addr2), .rom_addr(rom_addr2), .rom_sel(rom_sel2), .mem_we(mem_we2),
    .screen_bank(screen2), .paging_locked(locked2), .port_7ffd(p7_2), .port_1ffd(p1_2));

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m7 [3];
  logic [7:0] m1 [3];
  int allram_tbl [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 3, 4, 7, 6, 3};

  function automatic int cfg_banks(int c); return (c == 1) ? 64 : 8; endfunction
  function automatic int cfg_roms(int c);  return (c == 2) ? 4 : 2;  endfunction
  function automatic int cfg_mode(int c);  return c;                 endfunction
  function automatic int cfg_full(int c);  return (c == 2) ? 0 : 1;  endfunction

  function automatic bit m_locked(int c);
    return (cfg_banks(c) != 64) && m7[c][5];
  endfunction

  function automatic int m_sel_bank(int c);
    int b;
    b = int'(m7[c]) % 8;
    if (cfg_mode(c) != 0 && cfg_banks(c) >= 32) b += ((int'(m7[c]) / 64) % 4) * 8;
    if (cfg_banks(c) == 64) b += ((int'(m7[c]) / 32) % 2) * 32;
    return b % cfg_banks(c);
  endfunction

  function automatic bit m_hit7(int c, int a);
    if (cfg_full(c) != 0) return a == 32'h7FFD;
    if (cfg_mode(c) == 2) return (a / 16384) == 1 && ((a / 2) % 2) == 0;
    return a < 32768 && ((a / 2) % 2) == 0;
  endfunction

  function automatic bit m_hit1(int c, int a);
    if (cfg_mode(c) != 2) return 1'b0;
    if (cfg_full(c) != 0) return a == 32'h1FFD;
    return (a / 4096) == 1 && ((a / 2) % 2) == 0;
  endfunction

  // Physical address (RAM or ROM) for a CPU address; rom says which.
  function automatic int m_phys(int c, int a, output bit rom);
    int slot;
    int off;
    int bank;
    int page;
    slot = a / 16384;
    off  = a % 16384;
    if (cfg_mode(c) == 2 && m1[c][0]) begin
      rom  = 1'b0;
      bank = allram_tbl[((int'(m1[c]) / 2) % 4) * 4 + slot];
      return bank * 16384 + off;
    end
    if (slot == 0) begin
      rom  = 1'b1;
      page = int'(m7[c][4]);
      if (cfg_mode(c) == 2 && cfg_roms(c) == 4) page += 2 * int'(m1[c][2]);
      return page * 16384 + off;
    end
    rom = 1'b0;
    case (slot)
      1:       bank = 5;
      2:       bank = 2;
      default: bank = m_sel_bank(c);
    endcase
    return bank * 16384 + off;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m7[c] = 8'h00;
      m1[c] = 8'h00;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q0[$];
  logic [19:0] exp_q1[$];
  logic [19:0] exp_q2[$];

  task automatic push_exp(int c, logic [19:0] v);
    case (c)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic mon(int c, logic [19:0] addr);
    logic [19:0] e;
    int sz;
    case (c)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      check($sformatf("unexpected_mem_we%0d@%0h", c, addr), 32'd1, 32'd0);
    end else begin
      case (c)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      check($sformatf("mem_we_addr%0d", c), 32'(addr), 32'(e));
    end
  endtask

  always @(negedge clock) begin
    if (mem_we0) mon(0, 20'(mem_addr0));
    if (mem_we1) mon(1, mem_addr1);
    if (mem_we2) mon(2, 20'(mem_addr2));
  end

  // ---------------- state checks ----------------
  function automatic logic [31:0] get_mem(int c);
    case (c)
      0:       return 32'(mem_addr0);
      1:       return 32'(mem_addr1);
      default: return 32'(mem_addr2);
    endcase
  endfunction

  function automatic logic [31:0] get_rom(int c);
    case (c)
      0:       return 32'(rom_addr0);
      1:       return 32'(rom_addr1);
      default: return 32'(rom_addr2);
    endcase
  endfunction

  function automatic logic get_rom_sel(int c);
    case (c)
      0:       return rom_sel0;
      1:       return rom_sel1;
      default: return rom_sel2;
    endcase
  endfunction

  task automatic check_regs();
    check("p7_0", 32'(p7_0), 32'(m7[0]));
    check("p7_1", 32'(p7_1), 32'(m7[1]));
    check("p7_2", 32'(p7_2), 32'(m7[2]));
    check("p1_0", 32'(p1_0), 32'(m1[0]));
    check("p1_1", 32'(p1_1), 32'(m1[1]));
    check("p1_2", 32'(p1_2), 32'(m1[2]));
    check("locked0", 32'(locked0), 32'(m_locked(0)));
    check("locked1", 32'(locked1), 32'(m_locked(1)));
    check("locked2", 32'(locked2), 32'(m_locked(2)));
    check("screen0", 32'(screen0), 32'(m7[0][3]));
    check("screen1", 32'(screen1), 32'(m7[1][3]));
    check("screen2", 32'(screen2), 32'(m7[2][3]));
  endtask

  task automatic check_all();
    int a;
    int p;
    bit rom;
    check_regs();
    for (int s = 0; s < 4; s++) begin
      a = s * 16384 + int'($urandom_range(0, 16383));
      A = 16'(a);
      #1;
      for (int c = 0; c < 3; c++) begin
        p = m_phys(c, a, rom);
        check($sformatf("rom_sel%0d@%0h", c, a), 32'(get_rom_sel(c)), 32'(rom));
        if (rom) check($sformatf("rom_addr%0d@%0h", c, a), get_rom(c), 32'(p));
        else     check($sformatf("mem_addr%0d@%0h", c, a), get_mem(c), 32'(p));
      end
    end
  endtask

  // ---------------- drivers ----------------
  localparam int IO_WR  = 0;
  localparam int MEM_WR = 1;
  localparam int MEM_RD = 2;
  localparam int IO_RD  = 3;

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    tick();
    check_regs();
    check("mem_we_in_reset", 32'({mem_we0, mem_we1, mem_we2}), 32'd0);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic bus_cycle(int kind, logic [15:0] addr, logic [7:0] data, int hold);
    int p;
    bit rom;
    A = addr;
    D = data;
    tick();
    case (kind)
      IO_WR:  begin nIORQ = 1'b0; nWR = 1'b0; end
      MEM_WR: begin nMREQ = 1'b0; nWR = 1'b0; end
      MEM_RD: begin nMREQ = 1'b0; nRD = 1'b0; end
      default: begin nIORQ = 1'b0; nRD = 1'b0; end
    endcase
    for (int c = 0; c < 3; c++) begin
      if (kind == IO_WR && !m_locked(c)) begin
        if (m_hit7(c, int'(addr)))      m7[c] = data;
        else if (m_hit1(c, int'(addr))) m1[c] = data;
      end else if (kind == MEM_WR) begin
        p = m_phys(c, int'(addr), rom);
        if (!rom) push_exp(c, 20'(p));
      end
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (i == 2) D = 8'($urandom);
    end
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    repeat (3) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    logic [15:0] addr;
    reset_n = 1'b0;
    A = 16'h0000; D = 8'h00;
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    model_reset();
    tick(); tick();
    check_regs();
    reset_n = 1'b1;
    tick();

    // Long port write, data changing mid-cycle: one update with first data.
    bus_cycle(IO_WR, 16'h7FFD, 8'h03, 6);
    check("dir_7ffd_03", 32'(p7_0), 32'h03);
    A = 16'hC123; #1;
    check("dir_c123", 32'(mem_addr0), 32'h0C123);
    check_all();

    // Lock, then ignored write, then reset.
    do_reset();
    bus_cycle(IO_WR, 16'h7FFD, 8'h20, 2);
    bus_cycle(IO_WR, 16'h7FFD, 8'h07, 2);
    check("dir_locked", 32'(locked0), 32'd1);
    check("dir_lock_hold", 32'(p7_0), 32'h20);
    check_all();
    do_reset();
    check("dir_reset_7ffd", 32'(p7_0), 32'h00);

    // 64 banks, Pentagon: no lock, extended bank.
    bus_cycle(IO_WR, 16'h7FFD, 8'hE5, 3);
    A = 16'hC000; #1;
    check("dir_bank3d", 32'(mem_addr1), 32'hF4000);
    check("dir_nolock64", 32'(locked1), 32'd0);
    check_all();

    // +3 all-RAM and ROM page 3.
    do_reset();
    bus_cycle(IO_WR, 16'h1FFD, 8'h07, 2);
    A = 16'h0010; #1;
    check("dir_allram_sel", 32'(rom_sel2), 32'd0);
    check("dir_allram_bank4", 32'(mem_addr2), 32'h10010);
    bus_cycle(IO_WR, 16'h1FFD, 8'h04, 2);
    bus_cycle(IO_WR, 16'h7FFD, 8'h10, 2);
    A = 16'h0010; #1;
    check("dir_rom_page3", 32'(rom_addr2), 32'h0C010);
    check_all();

    // ROM write dropped; long RAM write gives one pulse.
    bus_cycle(MEM_WR, 16'h1000, 8'h55, 2);
    bus_cycle(MEM_WR, 16'h8000, 8'hAA, 4);
    check_all();

    // Strobe held across reset: nothing happens.
    do_reset();
    A = 16'h8000; nMREQ = 1'b0; nWR = 1'b0; reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    nMREQ = 1'b1; nWR = 1'b1;
    repeat (3) tick();
    A = 16'h7FFD; D = 8'h13; nIORQ = 1'b0; nWR = 1'b0; reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    repeat (3) tick();
    nIORQ = 1'b1; nWR = 1'b1;
    repeat (3) tick();
    check_all();

    // Reset arriving right after the strobe was sampled cancels the write.
    A = 16'hC000; tick();
    nMREQ = 1'b0; nWR = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    nMREQ = 1'b1; nWR = 1'b1;
    repeat (3) tick();
    check_all();

    // Randomised bus traffic.
    for (int n = 0; n < 160; n++) begin
      kind = int'($urandom_range(0, 19));
      if (kind == 0) begin
        do_reset();
      end else if (kind <= 9) begin
        case ($urandom_range(0, 3))
          0:       addr = 16'h7FFD;
          1:       addr = 16'h1FFD;
          2:       addr = 16'($urandom);
          default: addr = 16'($urandom) & 16'hFFFD;
        endcase
        bus_cycle(IO_WR, addr, 8'($urandom), int'($urandom_range(1, 6)));
      end else if (kind <= 15) begin
        bus_cycle(MEM_WR, 16'($urandom), 8'($urandom), int'($urandom_range(1, 6)));
      end else if (kind <= 17) begin
        bus_cycle(MEM_RD, 16'($urandom), 8'($urandom), int'($urandom_range(1, 4)));
      end else begin
        bus_cycle(IO_RD, 16'h7FFD, 8'($urandom), int'($urandom_range(1, 4)));
      end
      check_all();
    end

    repeat (4) tick();
    check("exp_q0_drained", 32'(exp_q0.size()), 32'd0);
    check("exp_q1_drained", 32'(exp_q1.size()), 32'd0);
    check("exp_q2_drained", 32'(exp_q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zx_memory_mapper.md
ZX_MEMORY_MAPPER -- requirements
Module: zx_memory_mapper

Interface
REQ-001 Parameter RAM_BANKS, default 8, number of 16K RAM banks; legal values 8, 32, 64.
REQ-002 Parameter ROM_PAGES, default 2, number of 16K ROM pages; legal values 2, 4.
REQ-003 Parameter MODE, default 0, paging scheme: 0 = 128K, 1 = Pentagon extended, 2 = +3 (adds port 1FFD).
REQ-004 Parameter FULL_DECODE, default 1: 1 = exact 16-bit port match; 0 = partial decode (see REQ-013).
REQ-005 clock  in  1  single block clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  synchronous, active-low reset.
REQ-007 A  in  16  Z80 address bus.
REQ-008 D  in  8  Z80 data bus, write data.
REQ-009 nMREQ, nIORQ, nRD, nWR  in  1 each  Z80 strobes, active low.
REQ-010 mem_addr  out  log2(RAM_BANKS)+14  physical RAM address; rom_addr  out  log2(ROM_PAGES)+14  physical ROM address.
REQ-011 rom_sel  out  1  current access targets ROM; mem_we  out  1  one-cycle RAM write pulse.
REQ-012 screen_bank  out  1  0 = bank 5, 1 = bank 7; paging_locked  out  1  lock state; port_7ffd, port_1ffd  out  8 each  register mirrors.

Function
REQ-013 Port decode: FULL_DECODE=1 matches A==7FFD / A==1FFD; FULL_DECODE=0 matches 7FFD on A[15]=0 & A[1]=0 (MODE 0/1), A[15:14]=01 & A[1]=0 (MODE 2); 1FFD on A[15:12]=0001 & A[1]=0 (MODE 2 only).
REQ-014 io_wr = nIORQ=0 & nWR=0 & nRD=1; mem_wr = nMREQ=0 & nWR=0; both registered once, then rising-edge detected; each Z80 write, however many clocks long, causes exactly one action.
REQ-015 Port write takes effect on the clock after the edge-detect cycle (2 clocks after strobe assertion is sampled); when paging_locked=1, port writes are ignored.
REQ-016 Bank select: RAM_BANKS=8 -> 7FFD[2:0]; 32 -> {7FFD[7:6],7FFD[2:0]}; 64 -> {7FFD[5],7FFD[7:6],7FFD[2:0]}; MODE 0 ignores bits 7:6.
REQ-017 Lock bit = 7FFD[5], except RAM_BANKS=64, where locking is disabled and paging_locked stays 0.
REQ-018 Normal map: 0000-3FFF ROM page {1FFD[2] (MODE 2 and ROM_PAGES=4 only, else 0), 7FFD[4]}; 4000 -> bank 5; 8000 -> bank 2; C000 -> selected bank.
REQ-019 MODE 2 with 1FFD[0]=1 (all-RAM): rom_sel=0 everywhere; 1FFD[2:1] = 00: 0,1,2,3; 01: 4,5,6,7; 10: 4,5,6,3; 11: 4,7,6,3.
REQ-020 mem_addr, rom_addr and rom_sel are combinational from A and the registers (zero latency, for synchronous RAM address).
REQ-021 mem_we pulses for one clock on the mem_wr edge, only when rom_sel=0 for the registered address; writes to ROM are dropped silently.
REQ-022 screen_bank = 7FFD[3]; upper bank-number bits absent for the configured RAM_BANKS read as 0.
REQ-023 A simultaneous io_wr edge and mem_wr edge cannot occur; if both are seen, the port write wins and mem_we stays 0.

Reset
REQ-024 While reset_n=0: port_7ffd=00, port_1ffd=00, paging_locked=0, mem_we=0, screen_bank=0.
REQ-025 On reset the edge-detect history is loaded as asserted, so a strobe already low when reset releases gives no pulse or port write.
REQ-026 Reset during an active write cancels it; no later pulse for that write.

Structure
REQ-027 Shared package zx_pkg holds the port constants (7FFD, 1FFD), fixed bank numbers (5, 2), the MODE encodings and the +3 all-RAM bank table.
REQ-028 One sub-module, zx_strobe_edge (register plus rising-edge pulse), is instantiated twice (io_wr, mem_wr).

Verification
REQ-029 Default params: OUT 7FFD,03 held 6 clocks -> one update; A=C123 -> mem_addr=0C123.
REQ-030 OUT 7FFD,20 then OUT 7FFD,07 -> paging_locked=1, port_7ffd stays 20; reset_n=0 one clock -> all 0.
REQ-031 RAM_BANKS=64, MODE=1: OUT 7FFD,E5 -> bank 3D, paging_locked=0; A=C000 -> mem_addr=F4000.
REQ-032 MODE=2, ROM_PAGES=4: OUT 1FFD,07 -> A=0010 gives rom_sel=0 with bank 4; OUT 1FFD,04 plus 7FFD,10 -> rom_addr=0C010.
REQ-033 Write to 1000 -> mem_we stays 0; write to 8000 held 4 clocks -> exactly one mem_we pulse.
REQ-034 Assert reset_n=0 with nWR low, release with nWR still low -> no mem_we and no register change.
